// File: rtl/bfly_pe_pipe_pkg.sv
// Shared defaults and arithmetic helpers for the butterfly pipeline.
package bfly_pe_pipe_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SHIFT = 16;
    // Internal arithmetic width; wide enough for any rounded product of a
    // sensible WIDTH without intermediate overflow.
    localparam int CALC_W = 128;

    // Half-LSB constant added before the arithmetic shift (round half up).
    function automatic logic signed [CALC_W-1:0] round_const(input int shift);
        logic signed [CALC_W-1:0] one;
        one = 1;
        if (shift <= 0) return '0;
        return one <<< (shift - 1);
    endfunction

    // Clamp v to the signed range of a width-bit word.
    function automatic logic signed [CALC_W-1:0] saturate(
        input logic signed [CALC_W-1:0] v,
        input int width
    );
        logic signed [CALC_W-1:0] one;
        logic signed [CALC_W-1:0] lim;
        one = 1;
        lim = one <<< (width - 1);
        if (v >= lim) return lim - one;
        if (v < -lim) return -lim;
        return v;
    endfunction

endpackage

// File: rtl/bfly_pe_pipe_round_sat.sv
// Per-lane output conditioning: optional round/shift, then narrowing to WIDTH
// by clamping or wrapping, with an out-of-range flag in both modes.
module pe_round_sat
    import bfly_pe_pipe_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int SHIFT  = DEF_SHIFT,
    parameter int SAT_EN = 1,
    parameter int IN_W   = 2 * DEF_WIDTH + 1
) (
    input  logic signed [IN_W-1:0]  value,
    input  logic                    round_en,
    output logic signed [WIDTH-1:0] result,
    output logic                    ovf
);

    logic signed [CALC_W-1:0] wide;
    logic signed [CALC_W-1:0] rounded;
    logic signed [CALC_W-1:0] clamped;

    // Round (products only), then range-check and narrow.
    always_comb begin
        wide    = CALC_W'(value);
        rounded = round_en ? ((wide + round_const(SHIFT)) >>> SHIFT) : wide;
        clamped = saturate(rounded, WIDTH);
        ovf     = (clamped != rounded);
        result  = (SAT_EN != 0) ? clamped[WIDTH-1:0] : rounded[WIDTH-1:0];
    end

endmodule

// File: rtl/bfly_pe_pipe.sv
// Three-stage radix-2 butterfly pair: add/sub, twiddle multiply, round/narrow.
module bfly_pe_pipe
    import bfly_pe_pipe_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int SHIFT  = DEF_SHIFT,
    parameter int SAT_EN = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic                    hold,
    input  logic signed [WIDTH-1:0] in0,
    input  logic signed [WIDTH-1:0] in1,
    input  logic signed [WIDTH-1:0] in2,
    input  logic signed [WIDTH-1:0] in3,
    input  logic signed [WIDTH-1:0] tf0,
    input  logic signed [WIDTH-1:0] tf1,
    input  logic                    bypass_n,
    input  logic                    clr_ovf,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] out0,
    output logic signed [WIDTH-1:0] out1,
    output logic signed [WIDTH-1:0] out2,
    output logic signed [WIDTH-1:0] out3,
    output logic                    ovf_sticky
);

    localparam int SW = WIDTH + 1;
    localparam int PW = 2 * WIDTH + 1;

    logic                 st1_v, st2_v;
    logic signed [SW-1:0] st1_s0, st1_s1, st1_d0, st1_d1;
    logic signed [WIDTH-1:0] st1_tf0, st1_tf1;
    logic                 st1_byp, st2_byp;
    logic signed [SW-1:0] st2_s0, st2_s1, st2_d0, st2_d1;
    logic signed [PW-1:0] st2_p0, st2_p1;

    logic signed [PW-1:0]    lane_val [4];
    logic                    lane_rnd [4];
    logic signed [WIDTH-1:0] lane_res [4];
    logic [3:0]              lane_ovf;

    // Stage 1: sums/differences, twiddles and mode captured with their data.
    always_ff @(posedge clk) begin
        if (reset) begin
            st1_v <= 1'b0;
        end else if (!hold) begin
            st1_v <= in_valid;
            if (in_valid) begin
                st1_s0  <= SW'(in0) + SW'(in1);
                st1_d0  <= SW'(in0) - SW'(in1);
                st1_s1  <= SW'(in2) + SW'(in3);
                st1_d1  <= SW'(in2) - SW'(in3);
                st1_tf0 <= tf0;
                st1_tf1 <= tf1;
                st1_byp <= bypass_n;
            end
        end
    end

    // Stage 2: full-precision twiddle products, sums/differences delayed.
    always_ff @(posedge clk) begin
        if (reset) begin
            st2_v <= 1'b0;
        end else if (!hold) begin
            st2_v <= st1_v;
            if (st1_v) begin
                st2_s0  <= st1_s0;
                st2_s1  <= st1_s1;
                st2_d0  <= st1_d0;
                st2_d1  <= st1_d1;
                st2_p0  <= PW'(st1_d0) * PW'(st1_tf0);
                st2_p1  <= PW'(st1_d1) * PW'(st1_tf1);
                st2_byp <= st1_byp;
            end
        end
    end

    // Lane selection: sums never rounded; difference lanes rounded only when multiplied.
    always_comb begin
        lane_val[0] = PW'(st2_s0);
        lane_val[1] = PW'(st2_s1);
        lane_val[2] = st2_byp ? st2_p0 : PW'(st2_d0);
        lane_val[3] = st2_byp ? st2_p1 : PW'(st2_d1);
        lane_rnd[0] = 1'b0;
        lane_rnd[1] = 1'b0;
        lane_rnd[2] = st2_byp;
        lane_rnd[3] = st2_byp;
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        pe_round_sat #(
            .WIDTH  (WIDTH),
            .SHIFT  (SHIFT),
            .SAT_EN (SAT_EN),
            .IN_W   (PW)
        ) u_round_sat (
            .value    (lane_val[g]),
            .round_en (lane_rnd[g]),
            .result   (lane_res[g]),
            .ovf      (lane_ovf[g])
        );
    end

    // Stage 3: output registers; data holds through bubbles, sticky flag set beats clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out0       <= '0;
            out1       <= '0;
            out2       <= '0;
            out3       <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            if (!hold) begin
                out_valid <= st2_v;
                if (st2_v) begin
                    out0 <= lane_res[0];
                    out1 <= lane_res[1];
                    out2 <= lane_res[2];
                    out3 <= lane_res[3];
                end
            end
            if (!hold && st2_v && (|lane_ovf)) ovf_sticky <= 1'b1;
            else if (clr_ovf)                   ovf_sticky <= 1'b0;
        end
    end

endmodule
